branch_predictor: RTL
=====================

# branch_predictor

Dynamic branch predictor that supplies the fetch stage's next-PC selection. It looks up the current fetch PC in a direct-mapped branch target buffer with 2-bit saturating counters and returns `prdt_taken_o`/`prdt_target_address_o` in the same cycle. The EX stage trains it with resolved branch outcomes. It also keeps a misprediction counter for performance monitoring.

## Interface
- `ENTRIES`, 64, number of BTB entries; power of 2, ≥4. `IDX_W = log2(ENTRIES)`.
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `pc_i`  in  32 (`InstAddrBus`)  current fetch PC.
- `ce_i`  in  1  fetch chip enable; predictions are suppressed when disabled.
- `ex_branch_i`  in  1  a resolved conditional branch or jump is in EX this cycle.
- `ex_pc_i`  in  32  PC of the resolved branch.
- `ex_taken_i`  in  1  actual outcome.
- `ex_target_i`  in  32 (`RegBus`)  actual target address.
- `ex_prdt_taken_i`  in  1  prediction that travelled with the instruction.
- `prdt_taken_o`  out  1  predict taken (`Branch`/`NotBranch`); combinational.
- `prdt_target_address_o`  out  32 (`RegBus`)  predicted target; combinational.
- `ready_o`  out  1  table initialised and predicting; registered.
- `mispredict_cnt_o`  out  32  count of resolved branches where `ex_prdt_taken_i != ex_taken_i`; registered.

## Operation
- Entry fields: `valid`, `tag = pc[31:2+IDX_W]`, `target[31:0]`, `ctr[1:0]`. Index is `pc[1+IDX_W:2]`.
- Counter encoding: 00 SNT, 01 WNT, 10 WT, 11 ST. Predict taken iff `ctr[1]`.
- FSM states:
  - **INIT** clears one entry per cycle (`valid<=0`, `ctr<=01`), with `idx` walking 0..ENTRIES-1. After it writes entry ENTRIES-1 it moves to RUN.
  - **RUN** is normal operation.
- Lookup: `prdt_taken_o = ready_o & ce_i & valid & tag_match & ctr[1]`. `prdt_target_address_o` is the entry target on a hit and 0 otherwise.
- Update, only in RUN when `ex_branch_i = 1`:
  - **Hit (tag match, valid):** the counter saturating-increments on taken and decrements on not-taken. If taken, `target <= ex_target_i`.
  - **Miss, taken:** allocate or replace the entry with `valid=1`, new tag, `target=ex_target_i`, `ctr=10`.
  - **Miss, not taken:** no table change.
- `mispredict_cnt_o` increments when `ex_branch_i & (ex_prdt_taken_i != ex_taken_i)`. It saturates at 0xFFFFFFFF and counts in both INIT and RUN.
- Updates arriving during INIT are dropped.

## Timing
- Reset values:
  - state=INIT, `idx`=0, `ready_o`=0, `mispredict_cnt_o`=0.
  - `prdt_taken_o`=0 and `prdt_target_address_o`=0 while `ready_o`=0.
- While `rst`=1 the FSM holds INIT with `idx=0`. Clearing starts on the first edge with `rst`=0. Entry k is cleared at edge k+1, and `ready_o` rises at edge ENTRIES, after the last clear.
- Lookup has zero latency and is combinational from `pc_i` and table state. This lets the PC register use it on the same edge.
- Table updates take effect on the edge after `ex_branch_i`. A lookup of the same index in the same cycle sees the old contents, with no bypass.
- When `pc_i` is held during a stall, the outputs stay stable unless an update lands on that index.
- Reset mid-operation: `ready_o` drops the cycle after `rst` is sampled high, and full re-initialisation follows. Table contents are not trusted until `ready_o`=1.

## Structure
- The following belong in shared `defines.v`:
  - `Branch` / `NotBranch`.
  - Counter encodings `CtrSNT`/`CtrWNT`/`CtrWT`/`CtrST`.
  - `RegBus` / `InstAddrBus`.
- Sub-module `bp_ctr2` is the combinational 2-bit saturating next-state function (`ctr_i`, `taken_i` → `ctr_o`).
- Storage is flop arrays, which keeps the read path combinational. No RAM macro is used.

## Test plan
Values use ENTRIES=64: index `pc[7:2]`, tag `pc[31:8]`.
- **Reset and init:** `rst`=1 for 2 cycles, then 0 → `ready_o`=0 for 63 edges and 1 from edge 64. `prdt_taken_o`=0 throughout for `pc_i`=0x100 with `ce_i`=1. An update issued at cycle 10 has no effect.
- **Allocate:** update pc=0x100, taken, target=0x80 → next cycle `pc_i`=0x100 gives `prdt_taken_o`=1 and target 0x80. With `ce_i`=0 it gives `prdt_taken_o`=0.
- **Hysteresis and saturation:**
  - After allocation, one not-taken update at 0x100 → ctr=01, predict 0.
  - One taken update → 10, predict 1.
  - Three more taken → 11.
  - One not-taken → 10, still predict 1.
- **Aliasing and no-alloc:**
  - `pc_i`=0x200 (same index as 0x100, different tag) → miss, predict 0.
  - Not-taken update at 0x200 → 0x100 still hits.
  - Taken update at 0x200, target 0x300 → 0x200 hits with 0x300, and 0x100 now misses.
- **Same-cycle update/lookup:** taken update at 0x40, target 0x1000, while `pc_i`=0x40 → `prdt_taken_o`=0 that cycle and 1 the next.
- **Counter and mid-run reset:**
  - 5 updates with `ex_prdt_taken_i != ex_taken_i` plus 3 matching → `mispredict_cnt_o`=5.
  - Then 1-cycle `rst` → counter 0, `ready_o`=0, and after re-init all prior entries miss.

Source files
------------

// File: rtl/branch_predictor_pkg.sv
// +--------------------------------------------------------------------------+
// | branch_predictor_pkg : shared widths, outcome and counter encodings. rev 1.0
// +--------------------------------------------------------------------------+
`default_nettype none

package branch_predictor_pkg;

  localparam int REG_BUS_W   = 32;
  localparam int INST_ADDR_W = 32;

  typedef logic [REG_BUS_W-1:0]   reg_bus_t;
  typedef logic [INST_ADDR_W-1:0] inst_addr_t;

  localparam logic BRANCH     = 1'b1;
  localparam logic NOT_BRANCH = 1'b0;

  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_WT  = 2'b10;
  localparam logic [1:0] CTR_ST  = 2'b11;

endpackage

`default_nettype wire

// File: rtl/bp_ctr2.sv
// +--------------------------------------------------------------------------+
// | bp_ctr2 : 2-bit saturating counter next-state function.           rev 1.0
// +--------------------------------------------------------------------------+
`default_nettype none

module bp_ctr2
  import branch_predictor_pkg::*;
(
  input  logic [1:0] ctr_i,
  input  logic       taken_i,
  output logic [1:0] ctr_o
);

  always_comb begin
    ctr_o = ctr_i;
    if (taken_i) begin
      if (ctr_i != CTR_ST) ctr_o = ctr_i + 2'd1;
    end else begin
      if (ctr_i != CTR_SNT) ctr_o = ctr_i - 2'd1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/branch_predictor.sv
// +--------------------------------------------------------------------------+
// | branch_predictor : direct-mapped BTB with 2-bit counters and a
// | misprediction counter; combinational lookup, EX-stage training.   rev 1.0
// +--------------------------------------------------------------------------+
`default_nettype none

module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int ENTRIES = 64
)
(
  input  logic        clk,
  input  logic        rst,
  input  inst_addr_t  pc_i,
  input  logic        ce_i,
  input  logic        ex_branch_i,
  input  inst_addr_t  ex_pc_i,
  input  logic        ex_taken_i,
  input  reg_bus_t    ex_target_i,
  input  logic        ex_prdt_taken_i,
  output logic        prdt_taken_o,
  output reg_bus_t    prdt_target_address_o,
  output logic        ready_o,
  output logic [31:0] mispredict_cnt_o
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = INST_ADDR_W - 2 - IDX_W;
  localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(ENTRIES - 1);

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic             r_valid  [ENTRIES];
  logic [TAG_W-1:0] r_tag    [ENTRIES];
  reg_bus_t         r_target [ENTRIES];
  logic [1:0]       r_ctr    [ENTRIES];

  logic [0:0]       r_state;
  logic [IDX_W-1:0] r_idx;
  logic             r_ready;
  logic [31:0]      r_mispredict_cnt;

  // Byte-offset bits never participate in index or tag.
  logic w_unused_pc_bits;
  assign w_unused_pc_bits = ^{pc_i[1:0], ex_pc_i[1:0]};

  // Fetch-side lookup
  logic [IDX_W-1:0] w_rd_idx;
  logic [TAG_W-1:0] w_rd_tag;
  logic             w_rd_hit;

  assign w_rd_idx = pc_i[1+IDX_W:2];
  assign w_rd_tag = pc_i[INST_ADDR_W-1:2+IDX_W];
  assign w_rd_hit = r_valid[w_rd_idx] && (r_tag[w_rd_idx] == w_rd_tag);

  assign prdt_taken_o = (r_ready && ce_i && w_rd_hit && r_ctr[w_rd_idx][1]) ? BRANCH : NOT_BRANCH;
  assign prdt_target_address_o = (r_ready && w_rd_hit) ? r_target[w_rd_idx] : '0;
  assign ready_o          = r_ready;
  assign mispredict_cnt_o = r_mispredict_cnt;

  // EX-side training
  logic [IDX_W-1:0] w_up_idx;
  logic [TAG_W-1:0] w_up_tag;
  logic             w_up_hit;
  logic [1:0]       w_up_ctr_next;

  assign w_up_idx = ex_pc_i[1+IDX_W:2];
  assign w_up_tag = ex_pc_i[INST_ADDR_W-1:2+IDX_W];
  assign w_up_hit = r_valid[w_up_idx] && (r_tag[w_up_idx] == w_up_tag);

  bp_ctr2 u_ctr2 (
    .ctr_i   (r_ctr[w_up_idx]),
    .taken_i (ex_taken_i),
    .ctr_o   (w_up_ctr_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_INIT;
      r_idx   <= '0;
      r_ready <= 1'b0;
    end else begin
      case (r_state)
        ST_INIT: begin
          r_idx <= r_idx + IDX_W'(1);
          if (r_idx == C_LAST_IDX) begin
            r_state <= ST_RUN;
            r_ready <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Table storage is left unreset; INIT scrubs it one entry per cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (r_state == ST_INIT) begin
        r_valid[r_idx] <= 1'b0;
        r_ctr[r_idx]   <= CTR_WNT;
      end else if (ex_branch_i) begin
        if (w_up_hit) begin
          r_ctr[w_up_idx] <= w_up_ctr_next;
          if (ex_taken_i) r_target[w_up_idx] <= ex_target_i;
        end else if (ex_taken_i) begin
          r_valid[w_up_idx]  <= 1'b1;
          r_tag[w_up_idx]    <= w_up_tag;
          r_target[w_up_idx] <= ex_target_i;
          r_ctr[w_up_idx]    <= CTR_WT;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mispredict_cnt <= '0;
    end else if (ex_branch_i && (ex_prdt_taken_i != ex_taken_i) &&
                 (r_mispredict_cnt != 32'hFFFF_FFFF)) begin
      r_mispredict_cnt <= r_mispredict_cnt + 32'd1;
    end
  end

endmodule

`default_nettype wire
